// File: rtl/mvm_engine.sv
// Matrix-vector multiply engine: y = sat((W*x) >>> QM) in Q(QN.QM).
// Optional round-half-up write-back under MVM_ROUND_NEAREST_EN.
module mvm_engine #(
  parameter int NROW  = 16,
  parameter int NCOL  = 16,
  parameter int QN    = 6,
  parameter int QM    = 11,
  parameter int LANES = 8,
  localparam int BW   = QN + QM + 1,
  localparam int P    = NROW / LANES,
  localparam int AW   = $clog2(NCOL),
  localparam int CW   = $clog2(NCOL + 1),
  localparam int ACCW = 2 * BW + AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CW-1:0]      ncols,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      colAddress,
  output logic               rdEn,
  input  logic [NROW*BW-1:0] weightRow,
  input  logic [BW-1:0]      inputElem,
  output logic [NROW*BW-1:0] outputVector,
  output logic               overflow
);

  localparam int PSW = (P > 1) ? $clog2(P) : 1;
  localparam int PW2 = 2 * BW;

  localparam logic signed [ACCW-1:0] MAXV =
    ACCW'((2 ** (BW - 1)) - 1);
  localparam logic signed [ACCW-1:0] MINV = ~MAXV;
`ifdef MVM_ROUND_NEAREST_EN
  localparam logic signed [ACCW-1:0] HALF =
    ACCW'(2 ** (QM - 1));
`endif

  if (NROW % LANES != 0) begin : g_bad_lanes
    $error("NROW must be a multiple of LANES");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN1,
    DRAIN2,
    WB,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]  cols;
  logic [CW-1:0]  ncols_eff;
  logic [AW-1:0]  col;
  logic [PSW-1:0] pass;
  logic           last_col;
  logic           last_pass;

  logic           v1, v2;
  logic [PSW-1:0] p1;

  logic signed [PW2-1:0]  prod [LANES];
  logic signed [ACCW-1:0] acc  [LANES];
  logic signed [ACCW-1:0] sh   [LANES];
  logic [BW-1:0]          res  [LANES];
  logic [LANES-1:0]       clamp;

  assign last_col  = (CW'(col) == cols - CW'(1));
  assign last_pass = (pass == PSW'(P - 1));

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign rdEn       = (state == ISSUE);
  assign colAddress = col;

  // Out-of-range column counts fall back to the full width.
  always_comb begin
    ncols_eff = ncols;
    if (ncols == '0 || ncols > CW'(NCOL))
      ncols_eff = CW'(NCOL);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = ISSUE;
      ISSUE:  if (last_col) state_nx = DRAIN1;
      DRAIN1: state_nx = DRAIN2;
      DRAIN2: state_nx = WB;
      WB:     state_nx = last_pass ? DONE : ISSUE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Run configuration, column and pass counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      cols <= '0;
      col  <= '0;
      pass <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cols <= ncols_eff;
            col  <= '0;
            pass <= '0;
          end
        end
        ISSUE: begin
          col <= last_col ? '0 : col + AW'(1);
        end
        WB: begin
          if (!last_pass) pass <= pass + PSW'(1);
        end
        default: ;
      endcase
    end
  end

  // Valid and pass tags travel with the read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      p1 <= '0;
    end else begin
      v1 <= rdEn;
      v2 <= v1;
      p1 <= pass;
    end
  end

  // Per-lane product register; lane l serves row l*P+pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) prod[l] <= '0;
    end else if (v1) begin
      for (int l = 0; l < LANES; l++)
        prod[l] <= $signed(weightRow[(l*P + int'(p1))*BW +: BW])
                 * $signed(inputElem);
    end
  end

  // Guard-bit accumulators, cleared on write-back.
  always_ff @(posedge clk) begin
    if (reset || state == WB) begin
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else if (v2) begin
      for (int l = 0; l < LANES; l++)
        acc[l] <= acc[l]
                + {{(ACCW-PW2){prod[l][PW2-1]}}, prod[l]};
    end
  end

  // Rescale and clamp each lane result.
  always_comb begin
    clamp = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef MVM_ROUND_NEAREST_EN
      sh[l] = (acc[l] + HALF) >>> QM;
`else
      sh[l] = acc[l] >>> QM;
`endif
      res[l] = sh[l][BW-1:0];
      if (sh[l] > MAXV) begin
        res[l]   = MAXV[BW-1:0];
        clamp[l] = 1'b1;
      end else if (sh[l] < MINV) begin
        res[l]   = MINV[BW-1:0];
        clamp[l] = 1'b1;
      end
    end
  end

  // Result rows of the current pass and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      outputVector <= '0;
      overflow     <= 1'b0;
    end else if (state == IDLE && start) begin
      overflow <= 1'b0;
    end else if (state == WB) begin
      for (int l = 0; l < LANES; l++)
        outputVector[(l*P + int'(pass))*BW +: BW] <= res[l];
      if (|clamp) overflow <= 1'b1;
    end
  end

endmodule
